// File: rtl/pool2d_stream.sv
// Streaming non-overlapping 2-D max/average pooling stage.
// Keeps one output row of per-channel accumulators; a single output register.
module pool2d_stream #(
    parameter int DATA_WIDTH   = 8,
    parameter int CHANNELS     = 1,
    parameter int IMAGE_HEIGHT = 6,
    parameter int IMAGE_WIDTH  = 6,
    parameter int POOL_SIZE    = 2,
    parameter int SIGNED       = 0
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           mode,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_features,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_features,
    output logic                           out_last
);

    localparam int LP = $clog2(POOL_SIZE);
    localparam int AW = DATA_WIDTH + 2 * LP;
    localparam int OH = IMAGE_HEIGHT / POOL_SIZE;
    localparam int OW = IMAGE_WIDTH / POOL_SIZE;
    localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int JW = (OW > 1) ? $clog2(OW) : 1;

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          mode_q;
    logic [AW-1:0] acc [OW][CHANNELS];

    logic          accept;
    logic          frame_start;
    logic          cur_mode;
    logic          in_crop;
    logic          win_first;
    logic          win_close;
    logic          last_win;
    logic [JW-1:0] j;
    logic [AW-1:0] nxt_acc [CHANNELS];
    logic [CHANNELS*DATA_WIDTH-1:0] res;

    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign frame_start = (row == '0) && (col == '0);
    assign cur_mode    = frame_start ? mode : mode_q;
    assign in_crop     = (int'(row) < OH * POOL_SIZE)
                      && (int'(col) < OW * POOL_SIZE);
    assign win_first   = (int'(row) % POOL_SIZE == 0)
                      && (int'(col) % POOL_SIZE == 0);
    assign win_close   = (int'(row) % POOL_SIZE == POOL_SIZE - 1)
                      && (int'(col) % POOL_SIZE == POOL_SIZE - 1);
    assign last_win    = (int'(row) == OH * POOL_SIZE - 1)
                      && (int'(col) == OW * POOL_SIZE - 1);
    assign j           = JW'(int'(col) / POOL_SIZE);

    // Per-channel window update and closing result for the current pixel
    always_comb begin
        logic [DATA_WIDTH-1:0] px;
        logic [AW-1:0]         pe;
        logic [AW-1:0]         a;
        logic [AW-1:0]         mx;
        logic [AW-1:0]         sum;
        logic [AW-1:0]         avg;
        logic                  gt;
        px  = '0;
        pe  = '0;
        a   = '0;
        mx  = '0;
        sum = '0;
        avg = '0;
        gt  = 1'b0;
        res = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            px = in_features[c*DATA_WIDTH +: DATA_WIDTH];
            if (SIGNED != 0) begin
                pe = AW'($signed(px));
            end else begin
                pe = AW'(px);
            end
            a = acc[j][c];
            if (SIGNED != 0) begin
                gt = $signed(pe) > $signed(a);
            end else begin
                gt = pe > a;
            end
            mx  = gt ? pe : a;
            sum = a + pe;
            if (SIGNED != 0) begin
                avg = AW'($signed(sum) >>> (2 * LP));
            end else begin
                avg = sum >> (2 * LP);
            end
            nxt_acc[c] = win_first ? pe : (cur_mode ? sum : mx);
            res[c*DATA_WIDTH +: DATA_WIDTH] =
                cur_mode ? avg[DATA_WIDTH-1:0] : mx[DATA_WIDTH-1:0];
        end
    end

    // Raster position, frame mode and partial-window accumulators
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row    <= '0;
            col    <= '0;
            mode_q <= 1'b0;
            for (int w = 0; w < OW; w++) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    acc[w][c] <= '0;
                end
            end
        end else if (accept) begin
            if (int'(col) == IMAGE_WIDTH - 1) begin
                col <= '0;
                if (int'(row) == IMAGE_HEIGHT - 1) begin
                    row <= '0;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
            if (frame_start) begin
                mode_q <= mode;
            end
            if (in_crop) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    acc[j][c] <= nxt_acc[c];
                end
            end
        end
    end

    // Output register: load on a closing beat, drop valid once taken
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_features <= '0;
        end else if (accept && in_crop && win_close) begin
            out_valid    <= 1'b1;
            out_features <= res;
            out_last     <= last_win;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench for pool2d_stream: max/avg, two lanes, backpressure,
// cropped 5x5 frames, signed pooling and mid-frame reset.
module tb_pool2d_stream;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // dut0: 6x6, two lanes, unsigned
    logic        md0 = 1'b0, v0 = 1'b0, irdy0, ov0, ordy0 = 1'b1, ol0;
    logic [15:0] in0 = '0, of0;
    // dut1: 5x5, one lane
    logic        md1 = 1'b0, v1 = 1'b0, irdy1, ov1, ordy1 = 1'b1, ol1;
    logic [7:0]  in1 = '0, of1;
    // dut2: 4x4 signed
    logic        md2 = 1'b0, v2 = 1'b0, irdy2, ov2, ordy2 = 1'b1, ol2;
    logic [7:0]  in2 = '0, of2;

    pool2d_stream #(.CHANNELS(2)) u0 (
        .clock(clock), .reset_n(reset_n), .mode(md0),
        .in_valid(v0), .in_ready(irdy0), .in_features(in0),
        .out_valid(ov0), .out_ready(ordy0), .out_features(of0),
        .out_last(ol0));

    pool2d_stream #(.IMAGE_HEIGHT(5), .IMAGE_WIDTH(5)) u1 (
        .clock(clock), .reset_n(reset_n), .mode(md1),
        .in_valid(v1), .in_ready(irdy1), .in_features(in1),
        .out_valid(ov1), .out_ready(ordy1), .out_features(of1),
        .out_last(ol1));

    pool2d_stream #(.IMAGE_HEIGHT(4), .IMAGE_WIDTH(4), .SIGNED(1)) u2 (
        .clock(clock), .reset_n(reset_n), .mode(md2),
        .in_valid(v2), .in_ready(irdy2), .in_features(in2),
        .out_valid(ov2), .out_ready(ordy2), .out_features(of2),
        .out_last(ol2));

    typedef struct {
        logic [15:0] f;
        logic        l;
        int          t;
    } beat_t;

    beat_t      q0[$];
    logic [7:0] q1[$];
    logic       q1l[$];
    logic [7:0] q2[$];
    logic       q2l[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit bp = 0;
    int ph = 0;
    int at[36];

    logic [7:0] img[36] = '{
        8, 1, 5, 3, 7, 4,
        6, 7, 2, 4, 9, 0,
        9, 0, 3, 2, 1, 5,
        1, 5, 6, 8, 2, 7,
        4, 3, 8, 1, 9, 6,
        2, 7, 5, 3, 4, 8};
    int mx_e[9] = '{8, 5, 9, 9, 8, 7, 7, 8, 9};
    int av_e[9] = '{5, 3, 5, 3, 4, 3, 4, 4, 6};
    int e5[4] = '{6, 8, 16, 18};
    byte img_s[16] = '{
        -3, 2, 100, -100,
        -8, -1, -128, 127,
        -5, -5, 0, -1,
        -5, -5, -1, -1};
    logic [7:0] e2[8] = '{8'h02, 8'h7F, 8'hFB, 8'h00,
                          8'hFD, 8'hFF, 8'hFB, 8'hFF};

    logic        st_prev = 1'b0;
    logic [15:0] st_f;
    logic        st_l;

    always @(posedge clock) cyc++;

    // Output capture plus hold and ready-rule checks
    always @(negedge clock) begin
        if (reset_n) begin
            if (ov0 && ordy0) q0.push_back('{of0, ol0, cyc});
            if (ov1 && ordy1) begin
                q1.push_back(of1);
                q1l.push_back(ol1);
            end
            if (ov2 && ordy2) begin
                q2.push_back(of2);
                q2l.push_back(ol2);
            end
            if (st_prev) begin
                total++;
                assert (ov0 === 1'b1 && of0 === st_f && ol0 === st_l)
                else begin
                    bad++;
                    $error("FAIL hold: v=%0b f=%h l=%0b need f=%h l=%0b",
                           ov0, of0, ol0, st_f, st_l);
                end
            end
            st_prev = ov0 && !ordy0;
            st_f = of0;
            st_l = ol0;
            total++;
            assert (irdy0 === !(ov0 && !ordy0))
            else begin
                bad++;
                $error("FAIL in_ready: got %0b need %0b",
                       irdy0, !(ov0 && !ordy0));
            end
        end else begin
            st_prev = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (bp) begin
            ordy0 = (ph == 0);
            ph = (ph + 1) % 3;
        end
    endtask

    task automatic send0(input logic [7:0] v, input logic m,
                         input int gap, output int t);
        repeat (gap) tick();
        v0 = 1'b1;
        in0 = {v + 8'd10, v};
        md0 = m;
        t = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (irdy0) begin
                t = cyc;
                break;
            end
            tick();
        end
        if (t < 0) begin
            total++;
            bad++;
            $error("FAIL send0_timeout: got no accept expected accept");
        end
        tick();
        v0 = 1'b0;
    endtask

    task automatic frame0(input logic m, input int gmax);
        for (int i = 0; i < 36; i++) begin
            send0(img[i], (i == 0) ? m : 1'($urandom_range(0, 1)),
                  (gmax > 0) ? int'($urandom_range(0, gmax)) : 0, at[i]);
        end
    endtask

    task automatic check0(input string tag, input int e[9], input bit lat);
        beat_t b;
        int ci;
        for (int k = 0; k < 200 && q0.size() < 9; k++) tick();
        chk({tag, "_count"}, q0.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (q0.size() == 0) break;
            b = q0.pop_front();
            chk($sformatf("%s_l0_%0d", tag, i), b.f[7:0], e[i]);
            chk($sformatf("%s_l1_%0d", tag, i), b.f[15:8], e[i] + 10);
            chk($sformatf("%s_last_%0d", tag, i), b.l, i == 8);
            if (lat) begin
                ci = (2 * (i / 3) + 1) * 6 + 2 * (i % 3) + 1;
                chk($sformatf("%s_lat_%0d", tag, i), b.t, at[ci] + 1);
            end
        end
        repeat (5) tick();
        chk({tag, "_extra"}, q0.size(), 0);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_ov", ov0, 0);
        chk("rst_ol", ol0, 0);
        chk("rst_of", of0, 0);
        chk("rst_ir", irdy0, 1);
        reset_n = 1'b1;
        tick();

        // max, mode flips after the first beat must be ignored
        frame0(1'b0, 0);
        check0("max", mx_e, 1);

        // average
        frame0(1'b1, 0);
        check0("avg", av_e, 1);

        // backpressure with random input gaps
        bp = 1;
        ph = 0;
        frame0(1'b0, 2);
        check0("bp", mx_e, 0);
        bp = 0;
        ordy0 = 1'b1;
        tick();

        // reset after 7 beats aborts the frame
        for (int i = 0; i < 7; i++) send0(img[i], 1'b1, 0, at[i]);
        reset_n = 1'b0;
        tick();
        tick();
        chk("mid_rst_ov", ov0, 0);
        chk("mid_rst_of", of0, 0);
        reset_n = 1'b1;
        tick();
        chk("mid_rst_q", q0.size(), 0);
        frame0(1'b0, 0);
        check0("post_rst", mx_e, 1);

        // 5x5 cropped, two back-to-back frames
        md1 = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 25; i++) begin
                v1 = 1'b1;
                in1 = 8'(i);
                tick();
            end
        end
        v1 = 1'b0;
        repeat (4) tick();
        chk("crop_count", q1.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (q1.size() == 0) break;
            chk($sformatf("crop_v_%0d", i), q1.pop_front(), e5[i % 4]);
            chk($sformatf("crop_l_%0d", i), q1l.pop_front(), (i % 4) == 3);
        end

        // signed 4x4: max frame then average frame back-to-back
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) begin
                v2 = 1'b1;
                md2 = (i == 0) ? 1'(f) : 1'(1 - f);
                in2 = img_s[i];
                tick();
            end
        end
        v2 = 1'b0;
        repeat (4) tick();
        chk("sgn_count", q2.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (q2.size() == 0) break;
            chk($sformatf("sgn_v_%0d", i), q2.pop_front(), e2[i]);
            chk($sformatf("sgn_l_%0d", i), q2l.pop_front(), (i % 4) == 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pool2d_stream.md
Name: pool2d_stream

Overview:
Streaming 2-D pooling stage for the MNIST feature pipeline, and the parametrised successor to the single-channel 2x2 max-pool stage. It takes a raster-order feature stream with CHANNELS lanes per beat. It performs non-overlapping POOL_SIZE x POOL_SIZE max or average pooling per channel. Results are emitted over a valid/ready stream to the next layer. It keeps a one-row partial-result buffer (OUT_WIDTH x CHANNELS accumulators) instead of storing whole frames.

Parameters:
DATA_WIDTH, 8, bits per feature element
CHANNELS, 1, parallel feature lanes per beat, all pooled independently
IMAGE_HEIGHT, 6, input rows per frame
IMAGE_WIDTH, 6, input columns per frame
POOL_SIZE, 2, window edge and stride; power of 2, >= 2
SIGNED, 0, 1 = features are two's complement for compare and average

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
mode  in  1  0 = max, 1 = average; sampled on first accepted beat of each frame
in_valid  in  1  input beat valid
in_ready  out  1  block can accept input beat
in_features  in  CHANNELS*DATA_WIDTH  input beat, channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output beat
out_features  out  CHANNELS*DATA_WIDTH  pooled result, same packing as in_features
out_last  out  1  high with the final output beat of a frame

Behaviour:
- Reset (async assert, sync release): row/col counters = 0, out_valid = 0, out_last = 0, out_features = 0, frame mode register = 0, accumulators cleared. in_ready = 1 after reset.
- Reset mid-frame aborts the frame. The next accepted beat is pixel (0,0) of a new frame, and no partial result is emitted.
- Geometry: OUT_HEIGHT = IMAGE_HEIGHT / POOL_SIZE and OUT_WIDTH = IMAGE_WIDTH / POOL_SIZE (floor).
  - Beats with row >= OUT_HEIGHT*POOL_SIZE or col >= OUT_WIDTH*POOL_SIZE are accepted and discarded.
- Handshake:
  - An input beat is accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (single output register, no combinational path from in_valid to out_valid).
  - An output beat transfers when out_valid && out_ready.
  - out_features and out_last are held stable while out_valid && !out_ready.
- Counters:
  - col increments per accepted beat and wraps at IMAGE_WIDTH-1, which increments row.
  - row wraps at IMAGE_HEIGHT-1, ending the frame.
  - Back-to-back frames are allowed with no idle cycle.
- Window accumulation per channel, per output column j = col / POOL_SIZE:
  - First pixel of a window (row%P==0 && col%P==0) loads acc[j].
  - Later pixels update acc[j]: max mode keeps the larger value, average mode adds.
  - Compare is unsigned when SIGNED=0 and signed otherwise.
  - Accumulator width is DATA_WIDTH + 2*log2(POOL_SIZE), so there is no overflow.
- Completion: the beat with row%P==P-1 && col%P==P-1 inside the cropped area closes window j.
  - On the next clock edge, out_features gets max(acc, pixel), or (acc+pixel) >> 2*log2(P).
  - The average shift is arithmetic when SIGNED=1 (floor rounding) and logical otherwise.
  - out_valid is set on that edge. Latency is 1 cycle from the accepted closing beat.
- out_last = 1 for the window at output (OUT_HEIGHT-1, OUT_WIDTH-1).
- Mode change mid-frame is ignored until the first beat of the next frame.
- Simultaneous output transfer and new closing-beat acceptance in the same cycle: the register reloads and out_valid stays 1, giving full throughput.

Test Plan:
- 6x6, P=2, CH=1, mode=0, raster input [8 1 5 3 7 4 / 6 7 2 4 9 0 / 9 0 3 2 1 5 / 1 5 6 8 2 7 / 4 3 8 1 9 6 / 2 7 5 3 4 8], out_ready=1 -> outputs 8,5,9,9,8,7,7,8,9 in order; out_last only on the 9th; each output 1 cycle after its closing beat.
- Same image, mode=1 -> outputs 5,3,5,3,4,3,4,4,6 (floor of sum/4).
- CH=2, lane1 = lane0 + 10, mode=0 -> lane0 as in the first test, lane1 = 18,15,19,19,18,17,17,18,19.
- Backpressure: out_ready toggles 1 cycle high / 2 cycles low and in_valid is random -> same 9 values as the first test, none lost or duplicated; out_features stable while stalled; in_ready low only when out_valid && !out_ready.
- 5x5 frame, P=2, all pixels = row*5+col -> 4 outputs = 6,8,16,18; row 4 and col 4 beats are accepted and dropped; a second frame immediately after gives identical results.
- SIGNED=1, window {-3,2,-8,-1}: mode=0 -> 2, mode=1 -> -3 (floor of -10/4). Reset pulsed after 7 beats of a frame -> no output, then a fresh frame gives correct results.
